spx_fifo_ctrl: RTL



---
 rtl/spx_fifo_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/spx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// spx_fifo_ctrl
// Turns one single-port synchronous RAM (one access per clock) into a FIFO
// with independent write and read handshakes. Reads own the RAM port first.
// A 2-entry write buffer holds accepted writes until a cycle is free to
// commit them. Read data comes straight from the RAM's output register.
// ---------------------------------------------------------------------------
module spx_fifo_ctrl #(
    parameter int ADDRBIT = 11,
    parameter int DEPTH   = 1536,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               wr_rdy,
    input  logic               rd_en,
    output logic               rd_rdy,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_vld,
    output logic [ADDRBIT:0]   level,
    output logic               wr_err,
    output logic               rd_err,
    output logic [ADDRBIT-1:0] ram_a,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_di,
    input  logic [WIDTH-1:0]   ram_do
);

    // Occupancy compares are done at ADDRBIT+1 bits so DEPTH == 2^ADDRBIT fits.
    localparam logic [ADDRBIT:0]   DEPTH_L  = (ADDRBIT + 1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_PTR = ADDRBIT'(DEPTH - 1);

    // What the single RAM port does this cycle.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_DRAIN
    } port_op_e;

    // Registered state
    logic [ADDRBIT-1:0] r_wptr;
    logic [ADDRBIT-1:0] r_rptr;
    logic [ADDRBIT:0]   r_cnt;      // committed RAM entries
    logic [1:0]         r_wb;       // write-buffer fill, 0..2
    logic [WIDTH-1:0]   r_wbuf [0:1];
    logic               r_rd_vld;
    logic               r_wr_err;
    logic               r_rd_err;

    // Combinational decode
    logic [ADDRBIT:0]   w_level;
    logic               w_wb_room;
    logic               w_wr_rdy;
    logic               w_rd_rdy;
    logic               w_push;
    logic               w_drain;
    logic               w_tail;
    logic [1:0]         w_wb_next;
    port_op_e           w_op;

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [ADDRBIT-1:0] next_ptr(input logic [ADDRBIT-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_level   = r_cnt + (ADDRBIT + 1)'(r_wb);
    assign w_wb_room = (r_wb != 2'd2);
    assign w_wr_rdy  = !rst && (w_level < DEPTH_L) && w_wb_room;
    // Reads stall while the buffer is full so the drain gets the port.
    assign w_rd_rdy  = !rst && (r_cnt != '0) && w_wb_room;

    assign w_push    = wr_en && w_wr_rdy;
    assign w_drain   = (w_op == OP_DRAIN);
    // After a pop the tail slot moves down by one.
    assign w_tail    = (r_wb == 2'd1) && !w_drain;
    assign w_wb_next = r_wb + {1'b0, w_push} - {1'b0, w_drain};

    // Port arbitration: accepted read first, then buffer drain, else idle read.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_op   = OP_IDLE;
        ram_we = 1'b0;
        ram_a  = r_rptr;
        ram_di = r_wbuf[0];
        if (rd_en && w_rd_rdy) begin
            w_op = OP_READ;
        end else if (!rst && (r_wb != 2'd0)) begin
            w_op   = OP_DRAIN;
            ram_we = 1'b1;
            ram_a  = r_wptr;
        end
    end

    // Pointers, counts and status pulses with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_wb     <= '0;
            r_rd_vld <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_rd_vld <= (w_op == OP_READ);
            r_wr_err <= wr_en && !w_wr_rdy;
            r_rd_err <= rd_en && !w_rd_rdy;
            r_wb     <= w_wb_next;
            case (w_op)
                OP_READ: begin
                    r_rptr <= next_ptr(r_rptr);
                    r_cnt  <= r_cnt - 1'b1;
                end
                OP_DRAIN: begin
                    r_wptr <= next_ptr(r_wptr);
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write-buffer payload: shift on pop, then store the new word at the tail.
    always_ff @(posedge clk) begin
        // NOTE: the payload slots carry no reset; r_wb alone says which are
        // meaningful, so clearing data would only add reset fan-out.
        if (w_drain) begin
            r_wbuf[0] <= r_wbuf[1];
        end
        if (w_push) begin
            r_wbuf[w_tail] <= wr_data;
        end
    end

    assign wr_rdy  = w_wr_rdy;
    assign rd_rdy  = w_rd_rdy;
    assign level   = w_level;
    assign rd_vld  = r_rd_vld;
    assign rd_data = ram_do;
    assign wr_err  = r_wr_err;
    assign rd_err  = r_rd_err;

endmodule
